// File: rtl/header_loader_if.sv
// Receive-side byte handshake between the USB receive path and the header loader.
//   rx_valid : source has a header byte on rx_data
//   rx_data  : header byte, arrival order = storage address order
//   rx_ready : loader accepts a byte on a rising edge where rx_valid && rx_ready
interface header_loader_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;

   modport master (output rx_valid, output rx_data, input  rx_ready);
   modport slave  (input  rx_valid, input  rx_data, output rx_ready);
endinterface

// File: rtl/header_loader.sv
// Header loader: turns the received header byte stream into one-cycle write
// strobes (data + byte address) for the header storage, flags a complete header
// and holds off further bytes until the hashing core consumes it. An inter-byte
// gap timeout and a flush input abort partial headers.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   rx                : byte handshake (slave side), see header_loader_if
//   flush             : synchronous abort of any partial or complete header
//   hdr_consumed      : hashing core has taken the complete header
//   o_data_en         : storage write strobe, one cycle per accepted byte
//   o_data/o_data_sel : byte and its storage address (held while o_data_en=0)
//   hdr_valid         : all header bytes written and stable in storage
//   timeout_err       : one-cycle pulse when a partial header is dropped on timeout
module header_loader #(
   parameter int unsigned HDR_BYTES      = 80,
   parameter int unsigned ADDR_W         = 7,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   header_loader_if.slave    rx,
   input  logic              flush,
   input  logic              hdr_consumed,
   output logic              o_data_en,
   output logic [7:0]        o_data,
   output logic [ADDR_W-1:0] o_data_sel,
   output logic              hdr_valid,
   output logic              timeout_err
);

   localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(HDR_BYTES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] FULL = 2'd2;

   logic [1:0]        state,     state_n;
   logic [ADDR_W-1:0] index,     index_n;
   logic [CNT_W-1:0]  gap_cnt,   gap_cnt_n;
   logic              ready_q,   ready_n;
   logic              data_en_n, hdr_valid_n, timeout_n;
   logic [7:0]        data_n;
   logic [ADDR_W-1:0] sel_n;
   logic              accept;

   // Registered ready, gated by flush so a byte offered during flush is refused.
   assign rx.rx_ready = ready_q & ~flush;

   // Next-state and next-output logic.
   always_comb begin
      state_n     = state;
      index_n     = index;
      gap_cnt_n   = '0;
      data_en_n   = 1'b0;
      data_n      = o_data;
      sel_n       = o_data_sel;
      timeout_n   = 1'b0;
      hdr_valid_n = 1'b0;
      ready_n     = 1'b0;
      accept      = rx.rx_valid & ready_q & ~flush;

      if (accept) begin
         data_en_n = 1'b1;
         data_n    = rx.rx_data;
         sel_n     = index;
      end

      case (state)
         IDLE, LOAD: begin
            if (accept) begin
               if (index == LAST_IDX) begin
                  state_n = FULL;
                  index_n = '0;
               end else begin
                  state_n = LOAD;
                  index_n = index + ADDR_W'(1);
               end
            end else if (state == LOAD && TIMEOUT_CYCLES != 0) begin
               // Gap counter reaches TIMEOUT_CYCLES on this edge: drop the partial header.
               if (gap_cnt == CNT_W'(TO_LAST)) begin
                  state_n   = IDLE;
                  index_n   = '0;
                  timeout_n = 1'b1;
               end else begin
                  gap_cnt_n = gap_cnt + CNT_W'(1);
               end
            end
         end
         FULL: begin
            if (hdr_consumed) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            index_n = '0;
         end
      endcase

      if (flush) begin
         state_n   = IDLE;
         index_n   = '0;
         gap_cnt_n = '0;
         timeout_n = 1'b0;
      end

      // hdr_valid trails FULL entry by one cycle so the last byte is already stored.
      hdr_valid_n = (state == FULL) && (state_n == FULL);
      ready_n     = (state_n != FULL);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         index       <= '0;
         gap_cnt     <= '0;
         ready_q     <= 1'b0;
         o_data_en   <= 1'b0;
         o_data      <= '0;
         o_data_sel  <= '0;
         hdr_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         index       <= index_n;
         gap_cnt     <= gap_cnt_n;
         ready_q     <= ready_n;
         o_data_en   <= data_en_n;
         o_data      <= data_n;
         o_data_sel  <= sel_n;
         hdr_valid   <= hdr_valid_n;
         timeout_err <= timeout_n;
      end
   end

endmodule

// File: tb/tb_header_loader.sv
// Self-checking bench for header_loader (TIMEOUT_CYCLES reduced to 16).
module tb_header_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       hdr_consumed = 1'b0;
   logic       o_data_en;
   logic [7:0] o_data;
   logic [6:0] o_data_sel;
   logic       hdr_valid;
   logic       timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   header_loader_if rx_bus ();

   header_loader #(.HDR_BYTES(80), .ADDR_W(7), .TIMEOUT_CYCLES(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx_bus),
      .flush        (flush),
      .hdr_consumed (hdr_consumed),
      .o_data_en    (o_data_en),
      .o_data       (o_data),
      .o_data_sel   (o_data_sel),
      .hdr_valid    (hdr_valid),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       flush;
      logic       consumed;
      logic       exp_ready;
      logic       exp_en;
      logic [7:0] exp_data;
      logic [6:0] exp_sel;
      logic       exp_hdr;
   } vec_t;

   vec_t tbl [28];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic f, input logic c,
                               input logic er, input logic ee, input logic [7:0] ed,
                               input logic [6:0] es, input logic eh);
      vec_t r;
      r.valid = v; r.data = d; r.flush = f; r.consumed = c;
      r.exp_ready = er; r.exp_en = ee; r.exp_data = ed; r.exp_sel = es; r.exp_hdr = eh;
      return r;
   endfunction

   // Offer one byte with no gap; it must be accepted and strobed right after the edge.
   task automatic send_byte(input logic [7:0] d, input logic [6:0] exp_sel);
      rx_bus.rx_valid = 1'b1;
      rx_bus.rx_data  = d;
      #1;
      chk("ready_before_byte", 32'(rx_bus.rx_ready), 32'd1);
      step();
      rx_bus.rx_valid = 1'b0;
      chk("strobe_en", 32'(o_data_en), 32'd1);
      chk("strobe_data", 32'(o_data), 32'(d));
      chk("strobe_sel", 32'(o_data_sel), 32'(exp_sel));
   endtask

   task automatic idle_cycle(input logic [7:0] held_data);
      rx_bus.rx_valid = 1'b0;
      step();
      chk("gap_no_strobe", 32'(o_data_en), 32'd0);
      chk("gap_data_held", 32'(o_data), 32'(held_data));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_en"},    32'(o_data_en),       32'd0);
      chk({tag, "_data"},  32'(o_data),          32'd0);
      chk({tag, "_sel"},   32'(o_data_sel),      32'd0);
      chk({tag, "_hdr"},   32'(hdr_valid),       32'd0);
      chk({tag, "_tout"},  32'(timeout_err),     32'd0);
      chk({tag, "_ready"}, 32'(rx_bus.rx_ready), 32'd0);
   endtask

   int tout_seen;

   initial begin
      rx_bus.rx_valid = 1'b0;
      rx_bus.rx_data  = 8'h00;

      // Cycle-level table: hold off in FULL, consume, ignored consume, flush with byte.
      for (int i = 0; i < 20; i++) tbl[i] = mk(1, 8'hAA, 0, 0, 0, 0, 8'h00, 7'd0, 1);
      tbl[20] = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 7'd0, 0);
      tbl[21] = mk(1, 8'h11, 0, 0, 1, 1, 8'h11, 7'd0, 0);
      tbl[22] = mk(1, 8'h22, 0, 1, 1, 1, 8'h22, 7'd1, 0);
      tbl[23] = mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 7'd0, 0);
      tbl[24] = mk(1, 8'h33, 1, 0, 0, 0, 8'h00, 7'd0, 0);
      tbl[25] = mk(1, 8'h44, 0, 0, 1, 1, 8'h44, 7'd0, 0);
      tbl[26] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 7'd0, 0);
      tbl[27] = mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 7'd0, 0);

      // Reset state, and rx_ready rises only on the first edge after release.
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      #1;
      chk("ready_low_before_first_edge", 32'(rx_bus.rx_ready), 32'd0);
      step();
      chk("ready_after_first_edge", 32'(rx_bus.rx_ready), 32'd1);

      // Back-to-back 80-byte header, data equal to address.
      for (int i = 0; i < 80; i++) send_byte(8'(i), 7'(i));
      chk("hdr_not_yet_valid", 32'(hdr_valid), 32'd0);
      chk("ready_low_in_full", 32'(rx_bus.rx_ready), 32'd0);
      idle_cycle(8'h4F);
      chk("hdr_valid_after_last", 32'(hdr_valid), 32'd1);

      // Table-driven cycles.
      for (int i = 0; i < 28; i++) begin
         rx_bus.rx_valid = tbl[i].valid;
         rx_bus.rx_data  = tbl[i].data;
         flush           = tbl[i].flush;
         hdr_consumed    = tbl[i].consumed;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(rx_bus.rx_ready), 32'(tbl[i].exp_ready));
         step();
         chk($sformatf("tbl%0d_en", i), 32'(o_data_en), 32'(tbl[i].exp_en));
         chk($sformatf("tbl%0d_hdr", i), 32'(hdr_valid), 32'(tbl[i].exp_hdr));
         chk($sformatf("tbl%0d_tout", i), 32'(timeout_err), 32'd0);
         if (tbl[i].exp_en) begin
            chk($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].exp_data));
            chk($sformatf("tbl%0d_sel", i), 32'(o_data_sel), 32'(tbl[i].exp_sel));
         end
      end
      rx_bus.rx_valid = 1'b0;
      flush = 1'b0;
      hdr_consumed = 1'b0;

      // Random gaps of 0..10 cycles over a full header.
      for (int i = 0; i < 80; i++) begin
         int gap;
         gap = int'($urandom_range(0, 10));
         for (int g = 0; g < gap; g++) idle_cycle((i == 0) ? 8'h44 : 8'((i - 1) ^ 8'h5A));
         send_byte(8'(i ^ 8'h5A), 7'(i));
      end
      idle_cycle(8'(79 ^ 8'h5A));
      chk("gaps_hdr_valid", 32'(hdr_valid), 32'd1);
      hdr_consumed = 1'b1;
      step();
      hdr_consumed = 1'b0;
      chk("gaps_consumed", 32'(hdr_valid), 32'd0);

      // Gap timeout after 30 bytes: pulse on the 16th idle cycle only.
      for (int i = 0; i < 30; i++) send_byte(8'(i + 8'h80), 7'(i));
      tout_seen = 0;
      for (int g = 1; g <= 16; g++) begin
         step();
         if (timeout_err) tout_seen++;
         if (g == 15) chk("no_timeout_before_limit", 32'(timeout_err), 32'd0);
      end
      chk("timeout_on_limit", 32'(timeout_err), 32'd1);
      chk("no_strobe_on_timeout", 32'(o_data_en), 32'd0);
      step();
      chk("timeout_single_cycle", 32'(timeout_err), 32'd0);
      chk("timeout_pulse_count", 32'(tout_seen), 32'd1);
      send_byte(8'hC3, 7'd0);

      // Return to IDLE, then flush together with a byte after 50 bytes.
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 50; i++) send_byte(8'(i + 8'h10), 7'(i));
      rx_bus.rx_valid = 1'b1;
      rx_bus.rx_data  = 8'hEE;
      flush = 1'b1;
      #1;
      chk("flush_ready_low", 32'(rx_bus.rx_ready), 32'd0);
      step();
      flush = 1'b0;
      rx_bus.rx_valid = 1'b0;
      chk("flush_no_strobe", 32'(o_data_en), 32'd0);
      chk("flush_no_timeout", 32'(timeout_err), 32'd0);
      for (int i = 0; i <= 40; i++) send_byte(8'(i + 8'h60), 7'(i));

      // Mid-load reset at byte 40: outputs clear immediately.
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      for (int i = 0; i < 80; i++) send_byte(8'(8'hFF - i), 7'(i));
      idle_cycle(8'(8'hFF - 79));
      chk("fresh_hdr_valid", 32'(hdr_valid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
